// File: rtl/rv_mem_pkg.sv
// Shared encodings for the MEM stage: funct3 codes, access sizes, FSM states
// and the records held while a bus access is outstanding.
package rv_mem_pkg;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_e;

    typedef struct packed {
        logic        we;
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [63:0] alu_result;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } pend_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
        logic [63:0] alu_result;
        logic [63:0] read_data;
    } wb_t;

    function automatic size_e size_of(input logic [2:0] funct3);
        return size_e'(funct3[1:0]);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the data bus: store strobe/data shift, alignment
// check, and load lane extraction with sign or zero extension.
module load_store_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] store_data_i,
    input  logic [63:0] load_raw_i,
    output logic [7:0]  wstrb_o,
    output logic [63:0] wdata_o,
    output logic        misaligned_o,
    output logic [63:0] load_data_o
);

    logic [5:0]  shamt;
    logic [63:0] lane;

    assign shamt   = {offset_i, 3'b000};
    assign wdata_o = store_data_i << shamt;
    assign lane    = load_raw_i >> shamt;

    always_comb begin
        misaligned_o = 1'b0;
        case (size_of(funct3_i))
            SZ_B:    misaligned_o = 1'b0;
            SZ_H:    misaligned_o = offset_i[0];
            SZ_W:    misaligned_o = |offset_i[1:0];
            SZ_D:    misaligned_o = |offset_i;
            default: misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        wstrb_o = 8'h00;
        case ({1'b0, funct3_i[1:0]})
            F3_SB:   wstrb_o = 8'h01 << offset_i;
            F3_SH:   wstrb_o = 8'h03 << offset_i;
            F3_SW:   wstrb_o = 8'h0F << offset_i;
            F3_SD:   wstrb_o = 8'hFF;
            default: wstrb_o = 8'h00;
        endcase
    end

    always_comb begin
        load_data_o = lane;
        case (funct3_i)
            F3_LB:   load_data_o = {{56{lane[7]}}, lane[7:0]};
            F3_LBU:  load_data_o = {56'd0, lane[7:0]};
            F3_LH:   load_data_o = {{48{lane[15]}}, lane[15:0]};
            F3_LHU:  load_data_o = {48'd0, lane[15:0]};
            F3_LW:   load_data_o = {{32{lane[31]}}, lane[31:0]};
            F3_LWU:  load_data_o = {32'd0, lane[31:0]};
            F3_LD:   load_data_o = lane;
            default: load_data_o = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: branch resolution, req/ack data-memory access with
// timeout, hazard stall, and the MEM/WB pipeline register.
module mem_access_stage
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              Branch,
    input  logic              Zero,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              Is_Greater,
    input  logic [63:0]       PCplusimm,
    input  logic [63:0]       ALU_result,
    input  logic [63:0]       WriteData,
    input  logic [3:0]        funct_in,
    input  logic [4:0]        rd,
    output logic              pc_src,
    output logic [63:0]       branch_target,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    output logic [7:0]        dmem_wstrb,
    input  logic [63:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              RegWrite_wb,
    output logic              MemtoReg_wb,
    output logic [63:0]       read_data_wb,
    output logic [63:0]       alu_result_wb,
    output logic [4:0]        rd_wb,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    pend_t            pend_q, pend_d;
    wb_t              wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misalign_q, misalign_d;
    logic             bus_err_q, bus_err_d;

    logic [2:0]  funct3;
    logic        in_idle, mem_op, rd_nz, start, done, expired, taken;
    logic [2:0]  sel_funct3, sel_offset;
    logic [7:0]  al_wstrb;
    logic [63:0] al_wdata, al_load;
    logic        al_misaligned;
    logic        unused_funct7;

    assign funct3        = funct_in[2:0];
    assign unused_funct7 = funct_in[3];
    assign in_idle       = (state_q == ST_IDLE);
    assign mem_op        = MemRead | MemWrite;
    assign rd_nz         = (rd != 5'd0);

    // Once the request is latched the aligner works from the held copy, so
    // the load lane is picked with the offset and size the bus was given.
    assign sel_funct3 = in_idle ? funct3 : pend_q.funct3;
    assign sel_offset = in_idle ? ALU_result[2:0] : pend_q.alu_result[2:0];

    load_store_align u_align (
        .funct3_i     (sel_funct3),
        .offset_i     (sel_offset),
        .store_data_i (WriteData),
        .load_raw_i   (dmem_rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .misaligned_o (al_misaligned),
        .load_data_o  (al_load)
    );

    assign start   = in_idle & mem_op & ~al_misaligned;
    assign done    = (state_q == ST_WAIT) & dmem_ack;
    assign expired = (state_q == ST_WAIT) & ~dmem_ack & (cnt_q == CNT_LAST);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = Zero;
            F3_BNE:  taken = ~Zero;
            F3_BLT:  taken = ~Zero & ~Is_Greater;
            F3_BGE:  taken = Zero | Is_Greater;
            default: taken = 1'b0;
        endcase
    end

    assign pc_src        = Branch & taken & in_idle;
    assign branch_target = PCplusimm;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path through the case can infer a latch.
        state_d    = state_q;
        pend_d     = pend_q;
        wb_d       = wb_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pend_d.we         = MemWrite;
                    pend_d.reg_write  = RegWrite & rd_nz;
                    pend_d.mem_to_reg = MemtoReg;
                    pend_d.rd         = rd;
                    pend_d.funct3     = funct3;
                    pend_d.alu_result = ALU_result;
                    pend_d.wdata      = al_wdata;
                    pend_d.wstrb      = al_wstrb;
                    state_d           = ST_ACCESS;
                end else begin
                    wb_d.reg_write  = RegWrite & rd_nz & ~(mem_op & al_misaligned);
                    wb_d.mem_to_reg = MemtoReg;
                    wb_d.rd         = rd;
                    wb_d.alu_result = ALU_result;
                    wb_d.read_data  = '0;
                    misalign_d      = mem_op & al_misaligned;
                end
            end
            ST_ACCESS: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    wb_d.reg_write  = pend_q.reg_write;
                    wb_d.mem_to_reg = pend_q.mem_to_reg;
                    wb_d.rd         = pend_q.rd;
                    wb_d.alu_result = pend_q.alu_result;
                    wb_d.read_data  = pend_q.we ? 64'd0 : al_load;
                    state_d         = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    wb_d.reg_write  = 1'b0;
                    wb_d.mem_to_reg = pend_q.mem_to_reg;
                    wb_d.rd         = pend_q.rd;
                    wb_d.alu_result = pend_q.alu_result;
                    wb_d.read_data  = '0;
                    bus_err_d       = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values from before this edge.
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            wb_q       <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            wb_q       <= wb_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Request and stall drop in the reset cycle itself, not one edge later.
    assign dmem_req   = ~reset & ((state_q == ST_ACCESS) | (state_q == ST_WAIT));
    assign stall      = ~reset & (start | (state_q == ST_ACCESS) |
                                  ((state_q == ST_WAIT) & ~done & ~expired));
    assign dmem_we    = pend_q.we;
    assign dmem_addr  = {pend_q.alu_result[ADDR_W-1:3], 3'b000};
    assign dmem_wdata = pend_q.wdata;
    assign dmem_wstrb = pend_q.wstrb;

    assign RegWrite_wb   = wb_q.reg_write;
    assign MemtoReg_wb   = wb_q.mem_to_reg;
    assign read_data_wb  = wb_q.read_data;
    assign alu_result_wb = wb_q.alu_result;
    assign rd_wb         = wb_q.rd;
    assign misalign_err  = misalign_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized loads, stores, ALU ops and branches against a byte-level model.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite, MemtoReg, Branch, Zero, MemWrite, MemRead, Is_Greater;
    logic [63:0] PCplusimm, ALU_result, WriteData;
    logic [3:0]  funct_in;
    logic [4:0]  rd;
    logic        pc_src;
    logic [63:0] branch_target;
    logic        stall, dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        RegWrite_wb, MemtoReg_wb;
    logic [63:0] read_data_wb, alu_result_wb;
    logic [4:0]  rd_wb;
    logic        misalign_err, bus_err;

    int checks = 0;
    int failures = 0;
    int last_stall_cycles;
    logic [7:0]  last_wstrb;
    logic [63:0] last_wdata;

    int          r_kind;
    bit          r_st;
    logic [2:0]  r_f3;
    logic [63:0] r_addr;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch), .Zero(Zero),
        .MemWrite(MemWrite), .MemRead(MemRead), .Is_Greater(Is_Greater),
        .PCplusimm(PCplusimm), .ALU_result(ALU_result), .WriteData(WriteData),
        .funct_in(funct_in), .rd(rd),
        .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
        .read_data_wb(read_data_wb), .alu_result_wb(alu_result_wb), .rd_wb(rd_wb),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h required=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_misaligned(input logic [63:0] a, input logic [2:0] f3);
        return (a % 64'(nbytes(f3))) != 64'd0;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [63:0] a, input logic [2:0] f3);
        logic [15:0] m;
        m = ((16'd1 << nbytes(f3)) - 16'd1) << (a % 64'd8);
        return m[7:0];
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [63:0] a, input logic [2:0] f3);
        logic [63:0] v, mask;
        int n;
        n = nbytes(f3);
        v = raw >> (64'd8 * (a % 64'd8));
        mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        v = v & mask;
        if (!f3[2] && n < 8 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input bit z, input bit g);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return !z && !g;
            3'd5:    return z || g;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        RegWrite = 0; MemtoReg = 0; Branch = 0; Zero = 0; MemWrite = 0; MemRead = 0;
        Is_Greater = 0; PCplusimm = 0; ALU_result = 0; WriteData = 0; funct_in = 0;
        rd = 0; dmem_ack = 0;
    endtask

    task automatic run_alu(input bit rw, input logic [4:0] rd_i, input logic [63:0] res);
        @(negedge clk);
        idle_inputs();
        RegWrite = rw; rd = rd_i; ALU_result = res; funct_in = 4'($urandom_range(0, 15));
        #1;
        check("alu_stall", stall, 0);
        check("alu_req", dmem_req, 0);
        @(negedge clk);
        check("alu_rw_wb", RegWrite_wb, rw && (rd_i != 0));
        check("alu_res_wb", alu_result_wb, res);
        check("alu_rd_wb", rd_wb, rd_i);
        check("alu_rdata_wb", read_data_wb, 0);
    endtask

    task automatic run_branch(input logic [2:0] f3, input bit z, input bit g, input logic [63:0] tgt);
        @(negedge clk);
        idle_inputs();
        Branch = 1; funct_in = {1'b0, f3}; Zero = z; Is_Greater = g; PCplusimm = tgt;
        #1;
        check("br_pc_src", pc_src, ref_taken(f3, z, g));
        check("br_target", branch_target, tgt);
    endtask

    // k = no-ack cycles spent in WAIT before the ack (ignored when give_ack = 0).
    task automatic run_mem(input bit is_st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [63:0] raw, input logic [4:0] rd_i,
                           input bit rw, input int k, input bit give_ack);
        int waits;
        @(negedge clk);
        idle_inputs();
        MemWrite = is_st; MemRead = is_st ? 1'($urandom_range(0, 1)) : 1'b1;
        RegWrite = rw; MemtoReg = !is_st; ALU_result = addr; WriteData = wd;
        funct_in = {1'b0, f3}; rd = rd_i;
        #1;
        last_stall_cycles = 0;
        if (ref_misaligned(addr, f3)) begin
            check("mis_stall", stall, 0);
            check("mis_req", dmem_req, 0);
            @(negedge clk);
            check("mis_err", misalign_err, 1);
            check("mis_rw_wb", RegWrite_wb, 0);
            idle_inputs();
            @(negedge clk);
            check("mis_err_pulse", misalign_err, 0);
            return;
        end
        check("start_stall", stall, 1);
        check("start_req", dmem_req, 0);
        last_stall_cycles += int'(stall);

        @(negedge clk);
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = {$urandom, $urandom};
        #1;
        check("acc_req", dmem_req, 1);
        check("acc_we", dmem_we, is_st);
        check("acc_addr", dmem_addr, addr - (addr % 64'd8));
        if (is_st) begin
            check("acc_wstrb", dmem_wstrb, ref_strb(addr, f3));
            check("acc_wdata", dmem_wdata, wd << (64'd8 * (addr % 64'd8)));
        end
        last_wstrb = dmem_wstrb;
        last_wdata = dmem_wdata;
        last_stall_cycles += int'(stall);

        waits = give_ack ? k : TIMEOUT - 1;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            dmem_ack = 0; Branch = 1; Zero = 1;
            #1;
            check("wait_req", dmem_req, 1);
            check("wait_pc_src", pc_src, 0);
            last_stall_cycles += int'(stall);
        end

        @(negedge clk);
        dmem_ack = give_ack;
        dmem_rdata = raw;
        #1;
        check("end_stall", stall, 0);
        check("end_req", dmem_req, 1);

        @(negedge clk);
        if (give_ack) begin
            check("wb_rw", RegWrite_wb, rw && (rd_i != 0));
            check("wb_rd", rd_wb, rd_i);
            check("wb_alu", alu_result_wb, addr);
            check("wb_m2r", MemtoReg_wb, !is_st);
            if (!is_st) check("wb_load", read_data_wb, ref_load(raw, addr, f3));
            check("wb_bus_err", bus_err, 0);
            check("stall_cycles", last_stall_cycles, 2 + k);
        end else begin
            check("to_bus_err", bus_err, 1);
            check("to_rw_wb", RegWrite_wb, 0);
        end
        idle_inputs();
        #1;
        check("post_stall", stall, 0);
        check("post_req", dmem_req, 0);
        if (!give_ack) begin
            @(negedge clk);
            check("to_bus_err_pulse", bus_err, 0);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        dmem_rdata = 0;
        repeat (2) @(negedge clk);
        check("rst_rw_wb", RegWrite_wb, 0);
        check("rst_m2r_wb", MemtoReg_wb, 0);
        check("rst_rdata_wb", read_data_wb, 0);
        check("rst_alu_wb", alu_result_wb, 0);
        check("rst_rd_wb", rd_wb, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_req", dmem_req, 0);
        check("rst_stall", stall, 0);
        reset = 0;

        run_mem(0, 3'b011, 64'h1000, 64'h0, 64'h8877665544332211, 5'd10, 1, 3, 1);
        check("ld_stall_cycles", last_stall_cycles, 5);
        check("ld_data", read_data_wb, 64'h8877665544332211);
        check("ld_rw", RegWrite_wb, 1);

        run_mem(0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd5, 1, 1, 1);
        check("lb_data", read_data_wb, 64'hFFFF_FFFF_FFFF_FF80);
        run_mem(0, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd5, 1, 1, 1);
        check("lbu_data", read_data_wb, 64'h80);

        run_mem(1, 3'b001, 64'h2006, 64'hBEEF, 64'h0, 5'd0, 0, 2, 1);
        check("sh_wstrb", last_wstrb, 8'hC0);
        check("sh_wdata_hi", last_wdata[63:48], 16'hBEEF);
        run_mem(0, 3'b010, 64'h2002, 64'h0, 64'h0, 5'd3, 1, 0, 1);

        run_branch(3'b000, 1, 0, 64'h0000_0000_0040_0100);
        check("beq_taken", pc_src, 1);
        run_branch(3'b101, 0, 0, 64'h0000_0000_0040_0200);
        check("bge_not_taken", pc_src, 0);

        run_mem(0, 3'b011, 64'h4000, 64'h0, 64'h0, 5'd9, 1, 0, 0);
        run_alu(1, 5'd4, 64'h1234);

        // Reset in the middle of WAIT, then a stray ack while idle.
        @(negedge clk);
        idle_inputs();
        MemRead = 1; RegWrite = 1; MemtoReg = 1; ALU_result = 64'h3000; funct_in = 4'b0011; rd = 5'd8;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_req", dmem_req, 1);
        reset = 1;
        #1;
        check("rst_mid_req", dmem_req, 0);
        @(negedge clk);
        reset = 0;
        idle_inputs();
        RegWrite = 1; rd = 5'd7; ALU_result = 64'h55; dmem_ack = 1; dmem_rdata = 64'hDEAD_BEEF;
        #1;
        check("rst_mid_rw_wb", RegWrite_wb, 0);
        check("rst_mid_rd_wb", rd_wb, 0);
        check("rst_mid_alu_wb", alu_result_wb, 0);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_req_after", dmem_req, 0);
        @(negedge clk);
        check("late_ack_rdata", read_data_wb, 0);
        check("late_ack_alu", alu_result_wb, 64'h55);
        check("late_ack_rw", RegWrite_wb, 1);
        check("late_ack_req", dmem_req, 0);
        idle_inputs();

        for (int n = 0; n < 40; n++) begin
            r_kind = $urandom_range(0, 3);
            if (r_kind <= 1) begin
                r_st = 1'(r_kind);
                r_f3 = r_st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
                r_addr = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) r_addr = r_addr - (r_addr % 64'(nbytes(r_f3)));
                run_mem(r_st, r_f3, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
                        5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 4), 1);
            end else if (r_kind == 2) begin
                run_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom});
            end else begin
                run_branch(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), {$urandom, $urandom});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
